uart_rx_packet_ctrl: RTL and testbench

Controller that sequences the 8-bit UART receiver and turns its byte stream into validated packets. It arms the receiver through `rx_enable` and detects each completed byte from the receiver's done flag. It hunts for a header, checks length and checksum, and buffers the payload. Accepted payloads are streamed out over a valid/ready interface toward the IoT processing logic.

---
 rtl/uart_rx_packet_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: arms an 8-bit UART receiver, frames HEADER/LEN/payload/CHK packets,
// and streams accepted payloads over a valid/ready interface.

module uart_rx_packet_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_done,
    input  logic [7:0] rx_byte,
    output logic       rx_enable,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       err_length,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic [7:0] pkt_count
);

    localparam int IW        = $clog2(MAX_LEN + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BUF_DEPTH = 1 << IW;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);
    localparam logic [IW-1:0] IDX_ZERO = '0;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HUNT    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;

    function automatic logic len_ok(input logic [7:0] len);
        len_ok = (len != 8'd0) && (len <= MAX_LEN8);
    endfunction

    logic [2:0]    r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_buf [0:BUF_DEPTH-1];
    logic          r_rx_enable;
    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic          r_out_last;
    logic          r_err_len;
    logic          r_err_chk;
    logic          r_err_tmo;
    logic [7:0]    r_pkt_count;

    logic          w_strobe;
    logic          w_in_pkt;
    logic          w_tmo_hit;
    logic [2:0]    w_state_nxt;
    logic [IW-1:0] w_len_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [7:0]    w_sum_nxt;
    logic          w_valid_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_last_nxt;
    logic          w_err_len_nxt;
    logic          w_err_chk_nxt;
    logic          w_err_tmo_nxt;
    logic [7:0]    w_cnt_nxt;
    logic          w_buf_we;

    assign w_strobe  = r_sync2 & ~r_sync3;
    assign w_in_pkt  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign w_tmo_hit = w_in_pkt && (r_tmo == TMO_LAST);

    // Two-flop synchronizer for rx_done plus the history flop for edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= rx_done;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Inter-byte timer; a timeout wins over a strobe landing on the same cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (!w_in_pkt || w_strobe || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Frame sequencing and output-stream next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_idx_nxt     = r_idx;
        w_sum_nxt     = r_sum;
        w_valid_nxt   = r_out_valid;
        w_data_nxt    = r_out_data;
        w_last_nxt    = r_out_last;
        w_err_len_nxt = 1'b0;
        w_err_chk_nxt = 1'b0;
        w_err_tmo_nxt = 1'b0;
        w_cnt_nxt     = r_pkt_count;
        w_buf_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_HUNT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HUNT: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_strobe && (rx_byte == HEADER)) begin
                    w_state_nxt = S_LEN;
                end else begin
                    w_state_nxt = S_HUNT;
                end
            end
            S_LEN: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_err_tmo_nxt = 1'b1;
                    w_state_nxt   = S_HUNT;
                end else if (w_strobe) begin
                    if (len_ok(rx_byte)) begin
                        w_len_nxt   = rx_byte[IW-1:0];
                        w_idx_nxt   = IDX_ZERO;
                        w_sum_nxt   = rx_byte;
                        w_state_nxt = S_PAYLOAD;
                    end else begin
                        w_err_len_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end
                end else begin
                    w_state_nxt = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_err_tmo_nxt = 1'b1;
                    w_state_nxt   = S_HUNT;
                end else if (w_strobe) begin
                    w_buf_we  = 1'b1;
                    w_sum_nxt = r_sum + rx_byte;
                    w_idx_nxt = r_idx + IDX_ONE;
                    if ((r_idx + IDX_ONE) == r_len) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end else begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_CHECK: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_err_tmo_nxt = 1'b1;
                    w_state_nxt   = S_HUNT;
                end else if (w_strobe) begin
                    if (rx_byte == r_sum) begin
                        // Preload the first payload byte so out_valid rises right after CHK
                        w_cnt_nxt   = r_pkt_count + 8'd1;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_buf[IDX_ZERO];
                        w_last_nxt  = (r_len == IDX_ONE);
                        w_idx_nxt   = IDX_ONE;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_err_chk_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_DRAIN: begin
                if (r_out_valid && out_ready) begin
                    if (r_out_last) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = enable ? S_HUNT : S_IDLE;
                    end else begin
                        w_data_nxt = r_buf[r_idx];
                        w_last_nxt = ((r_idx + IDX_ONE) == r_len);
                        w_idx_nxt  = r_idx + IDX_ONE;
                    end
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Payload storage; contents are don't-care until rewritten by the next packet
    always_ff @(posedge clock) begin
        if (w_buf_we) begin
            r_buf[r_idx] <= rx_byte;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_sum       <= 8'd0;
            r_rx_enable <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_last  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_pkt_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_sum       <= w_sum_nxt;
            r_rx_enable <= w_in_pkt || (r_state == S_HUNT);
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_out_last  <= w_last_nxt;
            r_err_len   <= w_err_len_nxt;
            r_err_chk   <= w_err_chk_nxt;
            r_err_tmo   <= w_err_tmo_nxt;
            r_pkt_count <= w_cnt_nxt;
        end
    end

    assign rx_enable    = r_rx_enable;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign err_length   = r_err_len;
    assign err_checksum = r_err_chk;
    assign err_timeout  = r_err_tmo;
    assign pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Self-checking bench for uart_rx_packet_ctrl: directed frames from the test plan plus
// randomized frames judged by a byte-stream parser model.

module tb_uart_rx_packet_ctrl;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         TMO     = 50;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       enable    = 1'b0;
    logic       rx_done   = 1'b0;
    logic [7:0] rx_byte   = 8'd0;
    logic       out_ready = 1'b0;
    logic       rx_enable;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       err_length;
    logic       err_checksum;
    logic       err_timeout;
    logic [7:0] pkt_count;

    uart_rx_packet_ctrl #(
        .MAX_LEN        (MAX_LEN),
        .HEADER         (HDR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .rx_done      (rx_done),
        .rx_byte      (rx_byte),
        .rx_enable    (rx_enable),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_length   (err_length),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .pkt_count    (pkt_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Observed stream and error pulse counts
    logic [8:0] act_q[$];
    int         cnt_len = 0;
    int         cnt_chk = 0;
    int         cnt_tmo = 0;
    int         rdy_mode = 0;

    // Expected stream from the model
    logic [7:0] stim_q[$];
    logic [8:0] exp_q[$];
    int         exp_len = 0;
    int         exp_chk = 0;
    int         exp_tmo = 0;
    int         exp_pkts = 0;

    // Drives out_ready, records transfers, checks hold-while-stalled and back-to-back streaming
    initial begin
        logic       prev_stall;
        logic       prev_more;
        logic [8:0] prev_word;
        prev_stall = 1'b0;
        prev_more  = 1'b0;
        prev_word  = 9'd0;
        forever begin
            @(negedge clock);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ~out_ready;
            endcase
            if (!reset) begin
                prev_stall = 1'b0;
                prev_more  = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk_eq("hold_valid", 32'(out_valid), 32'd1);
                    chk_eq("hold_data", 32'({out_last, out_data}), 32'(prev_word));
                end
                if (prev_more) begin
                    chk_eq("next_valid", 32'(out_valid), 32'd1);
                end
                prev_stall = out_valid && !out_ready;
                prev_more  = out_valid && out_ready && !out_last;
                prev_word  = {out_last, out_data};
                if (out_valid && out_ready) begin
                    act_q.push_back({out_last, out_data});
                end
                cnt_len += int'(err_length);
                cnt_chk += int'(err_checksum);
                cnt_tmo += int'(err_timeout);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        tick(4);
        rx_done = 1'b0;
        tick($urandom_range(2, 6));
    endtask

    // Walks stim_q applying the framing rules: hunt header, validate length, sum-check
    task automatic model_parse();
        int         i;
        int         n;
        int         len;
        logic [7:0] sum;
        i = 0;
        n = stim_q.size();
        while (i < n) begin
            if (stim_q[i] != HDR) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            len = int'(stim_q[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                exp_len++;
                i += 2;
                continue;
            end
            if (i + 2 + len >= n) break;
            sum = stim_q[i+1];
            for (int k = 0; k < len; k++) sum = sum + stim_q[i+2+k];
            if (stim_q[i+2+len] == sum) begin
                exp_pkts++;
                for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), stim_q[i+2+k]});
            end else begin
                exp_chk++;
            end
            i += len + 3;
        end
    endtask

    task automatic run_frame(input string tag);
        logic done;
        model_parse();
        foreach (stim_q[k]) send_byte(stim_q[k]);
        done = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (act_q.size() >= exp_q.size() && !out_valid) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        chk_eq({tag, "_drain_done"}, 32'(done), 32'd1);
        tick(3);
        chk_eq({tag, "_xfer_count"}, act_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
            chk_eq({tag, "_byte"}, 32'(act_q[k]), 32'(exp_q[k]));
        chk_eq({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts[7:0]));
        chk_eq({tag, "_err_length"}, cnt_len, exp_len);
        chk_eq({tag, "_err_checksum"}, cnt_chk, exp_chk);
        chk_eq({tag, "_err_timeout"}, cnt_tmo, exp_tmo);
        act_q.delete();
        exp_q.delete();
        stim_q.delete();
    endtask

    task automatic push_good(input logic [7:0] len, input logic [7:0] seed);
        logic [7:0] sum;
        logic [7:0] b;
        stim_q.push_back(HDR);
        stim_q.push_back(len);
        sum = len;
        for (int k = 0; k < int'(len); k++) begin
            b = seed + 8'(k * 7);
            stim_q.push_back(b);
            sum = sum + b;
        end
        stim_q.push_back(sum);
    endtask

    task automatic build_random();
        int         kind;
        int         len;
        logic [7:0] b;
        logic [7:0] sum;
        kind = $urandom_range(0, 9);
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h00;
            stim_q.push_back(b);
        end
        stim_q.push_back(HDR);
        if (kind == 0) begin
            stim_q.push_back(8'h00);
        end else if (kind == 1) begin
            stim_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        end else begin
            len = $urandom_range(1, MAX_LEN);
            stim_q.push_back(8'(len));
            sum = 8'(len);
            repeat (len) begin
                b = 8'($urandom_range(0, 255));
                stim_q.push_back(b);
                sum = sum + b;
            end
            if (kind == 2) stim_q.push_back(sum ^ 8'($urandom_range(1, 255)));
            else           stim_q.push_back(sum);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   n;
        logic seen;

        tick(3);
        chk_eq("rst_rx_enable", 32'(rx_enable), 32'd0);
        chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_out_last", 32'(out_last), 32'd0);
        chk_eq("rst_out_data", 32'(out_data), 32'd0);
        chk_eq("rst_errors", 32'({err_length, err_checksum, err_timeout}), 32'd0);
        chk_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b1;
        tick(2);
        chk_eq("idle_rx_enable", 32'(rx_enable), 32'd0);
        enable = 1'b1;
        tick(3);
        chk_eq("hunt_rx_enable", 32'(rx_enable), 32'd1);

        rdy_mode = 0;
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_frame("good");

        stim_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
        run_frame("badchk");
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_frame("after_badchk");

        stim_q = '{8'hA5, 8'h00};
        run_frame("len_zero");
        stim_q = '{8'hA5, 8'h11};
        run_frame("len_over");
        push_good(8'h10, 8'h3C);
        run_frame("len_max");

        rdy_mode = 2;
        stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_frame("noise_toggle");
        rdy_mode = 1;
        push_good(8'h0B, 8'hE1);
        run_frame("random_ready");

        // Timeout: A5 04 11 then silence
        rdy_mode = 0;
        send_byte(8'hA5);
        send_byte(8'h04);
        rx_byte = 8'h11;
        rx_done = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 4) rx_done = 1'b0;
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        chk_eq("tmo_seen", 32'(seen), 32'd1);
        chk_eq("tmo_latency", n, 3 + TMO);
        exp_tmo++;
        tick(3);
        chk_eq("tmo_count", cnt_tmo, exp_tmo);
        chk_eq("tmo_hunt_rx_enable", 32'(rx_enable), 32'd1);
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_frame("after_tmo");

        // Disable mid-packet
        send_byte(8'hA5);
        send_byte(8'h03);
        enable = 1'b0;
        tick(3);
        chk_eq("dis_rx_enable", 32'(rx_enable), 32'd0);
        send_byte(8'hA5);
        chk_eq("dis_out_valid", 32'(out_valid), 32'd0);
        enable = 1'b1;
        tick(3);
        chk_eq("reen_rx_enable", 32'(rx_enable), 32'd1);
        push_good(8'h02, 8'h40);
        run_frame("after_disable");

        // Reset during payload
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b0;
        tick(1);
        chk_eq("mid_rst_rx_enable", 32'(rx_enable), 32'd0);
        chk_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        chk_eq("mid_rst_errors", 32'({err_length, err_checksum, err_timeout}), 32'd0);
        reset = 1'b1;
        exp_pkts = 0;
        tick(3);
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_frame("after_reset");

        repeat (40) begin
            rdy_mode = $urandom_range(0, 2);
            build_random();
            run_frame("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
